func_dispatch: RTL and testbench
================================

# func_dispatch

Operand-side front end for the `func` unit (y = a³ + ⌊√b⌋). It accepts (a, b) pairs on a valid/ready stream into a small FIFO, issues them one at a time to `func` over its start/busy handshake, and captures each result into an output slot presented on a valid/ready stream. This lets upstream logic push bursts without tracking `func`'s variable latency. Results leave in strict input order.

## Interface
- `DEPTH`, 4, operand FIFO depth in entries; power of two, ≥ 2.
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset; one clock; reset is asynchronous and active-low.
- `in_valid_i` in 1: operand pair valid.
- `in_ready_o` out 1: FIFO can accept; equals !full.
- `a_bi` in 8: operand a.
- `b_bi` in 8: operand b.
- `out_valid_o` out 1: result slot full.
- `out_ready_i` in 1: downstream takes the result.
- `y_bo` out 25: result; held stable while `out_valid_o`=1.
- `fn_start_o` out 1: start pulse to `func`; registered.
- `fn_a_bo` out 8: a to `func`; registered.
- `fn_b_bo` out 8: b to `func`; registered.
- `fn_busy_i` in 1: `func` busy.
- `fn_y_bi` in 25: `func` result, valid when `fn_busy_i`=0 after a job.
- `cnt_bo` out 16: completed-job count (only with `FUNC_DISPATCH_CNT_EN`).

## Operation
- FIFO: push on `in_valid_i && in_ready_o`; DEPTH entries of {a, b}; read/write pointers wrap modulo DEPTH. Full/empty are derived from a pointer-width+1 count. No push occurs while full, regardless of a same-cycle pop.
- FSM states:
  - IDLE: if FIFO non-empty and slot empty, pop the head, load `fn_a_bo`/`fn_b_bo`, set `fn_start_o`=1, and go to ISSUE.
  - ISSUE: clear `fn_start_o` and go to WAIT. `func` samples start at this edge and raises busy for the following cycle.
  - WAIT: when `fn_busy_i`=0, load `y_bo` ← `fn_y_bi`, set `out_valid_o`=1, and go to IDLE.
- `fn_a_bo`/`fn_b_bo` stay stable from ISSUE until the next pop.
- Slot: cleared on `out_valid_o && out_ready_i`. IDLE does not pop while the slot is full, so a held result stalls dispatch.
- When the slot is consumed at edge E, IDLE may pop at edge E+1. The slot is never loaded and drained on the same edge.
- No arithmetic is done here. `y_bo` is a direct 25-bit copy of `fn_y_bi`.

## Timing
- Reset values: `in_ready_o`=1, `out_valid_o`=0, `y_bo`=0, `fn_start_o`=0, `fn_a_bo`=0, `fn_b_bo`=0, `cnt_bo`=0, FSM=IDLE, FIFO empty.
- Reset mid-operation drops all queued and in-flight jobs. `func` shares the same reset event.
- Push at edge E0 into an empty FIFO, with the slot empty:
  - Pop at E1; `fn_start_o` is high during E1→E2.
  - WAIT begins at E2.
  - A result is seen with busy low at edge Ek; `out_valid_o` is high from Ek.
- Minimum issue-to-issue spacing: 3 cycles plus `func` latency plus the slot drain.
- `fn_start_o` is high for exactly one cycle per job and is never high outside ISSUE.

## Configuration
- `FUNC_DISPATCH_CNT_EN` defined:
  - A 16-bit `cnt_bo` increments on each slot load (WAIT→IDLE).
  - It wraps from 65535 to 0 and resets to 0.
- Not defined: the `cnt_bo` port and its counter are absent.

## Test plan
- Single job (2, 10), `out_ready_i`=1 → one `fn_start_o` pulse; `y_bo`=11 with `out_valid_o` for 1 cycle.
- Back-to-back (255, 255), (16, 143), (43, 11) → results in order: 16581390, 4107, 79510.
- Backpressure with DEPTH=4: push 6 pairs, the first five being (2, 10), (255, 255), (16, 143), (43, 11), (54, 11), with `out_ready_i`=0.
  - Required: 5 accepted and `in_ready_o`=0 on the 6th.
  - Then `out_ready_i`=1 → results 11, 16581390, 4107, 79510, 157467, followed by the 6th.
- Edge values (0, 0), (1, 1), (200, 200) → 0, 2, 8000014.
- Reset asserted in WAIT with 2 entries queued → `out_valid_o`=0 and `in_ready_o`=1 immediately; no further `fn_start_o` after release.
- With `FUNC_DISPATCH_CNT_EN`: after the 10 jobs above, `cnt_bo`=10.

Source files
------------

// File: rtl/func_dispatch_if.sv
// Handshake bundle between func_dispatch, its upstream/downstream streams and the func unit.
// The slave modport is the dispatcher's view; master is the environment driving it.
interface func_dispatch_if;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [7:0]  a_bi;
    logic [7:0]  b_bi;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [24:0] y_bo;
    logic        fn_start_o;
    logic [7:0]  fn_a_bo;
    logic [7:0]  fn_b_bo;
    logic        fn_busy_i;
    logic [24:0] fn_y_bi;

    modport slave (
        input  in_valid_i, a_bi, b_bi, out_ready_i, fn_busy_i, fn_y_bi,
        output in_ready_o, out_valid_o, y_bo, fn_start_o, fn_a_bo, fn_b_bo
    );

    modport master (
        output in_valid_i, a_bi, b_bi, out_ready_i, fn_busy_i, fn_y_bi,
        input  in_ready_o, out_valid_o, y_bo, fn_start_o, fn_a_bo, fn_b_bo
    );
endinterface

// File: rtl/func_dispatch.sv
// Operand FIFO plus issue FSM feeding the func unit; results leave in input order via a one-entry slot.
// Optional completed-job counter cnt_bo is built when FUNC_DISPATCH_CNT_EN is defined.
module func_dispatch #(
    parameter int DEPTH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    func_dispatch_if.slave bus
`ifdef FUNC_DISPATCH_CNT_EN
    ,
    output logic [15:0]    cnt_bo
`endif
);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state_q;
    logic [7:0]        mem_a_q [DEPTH];
    logic [7:0]        mem_b_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full, empty, push, pop;
    logic              fn_start_q, out_valid_q;
    logic [7:0]        fn_a_q, fn_b_q;
    logic [24:0]       y_q;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);
    // A same-cycle pop does not free room for a push while full.
    assign push  = bus.in_valid_i && !full;
    assign pop   = (state_q == IDLE) && !empty && !out_valid_q;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= bus.a_bi;
            mem_b_q[wr_ptr_q] <= bus.b_bi;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

`ifdef FUNC_DISPATCH_CNT_EN
    logic [15:0] cnt_q;
    assign cnt_bo = cnt_q;
`endif

    // The slot is only loaded in WAIT, which is entered with the slot empty,
    // so load and drain never collide on one edge.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            fn_start_q  <= 1'b0;
            fn_a_q      <= '0;
            fn_b_q      <= '0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
`ifdef FUNC_DISPATCH_CNT_EN
            cnt_q       <= '0;
`endif
        end else begin
            if (out_valid_q && bus.out_ready_i) out_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        fn_a_q     <= mem_a_q[rd_ptr_q];
                        fn_b_q     <= mem_b_q[rd_ptr_q];
                        fn_start_q <= 1'b1;
                        state_q    <= ISSUE;
                    end
                end
                ISSUE: begin
                    fn_start_q <= 1'b0;
                    state_q    <= WAIT;
                end
                WAIT: begin
                    if (!bus.fn_busy_i) begin
                        y_q         <= bus.fn_y_bi;
                        out_valid_q <= 1'b1;
`ifdef FUNC_DISPATCH_CNT_EN
                        cnt_q       <= cnt_q + 16'd1;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    fn_start_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready_o  = !full;
    assign bus.out_valid_o = out_valid_q;
    assign bus.y_bo        = y_q;
    assign bus.fn_start_o  = fn_start_q;
    assign bus.fn_a_bo     = fn_a_q;
    assign bus.fn_b_bo     = fn_b_q;
endmodule

// File: tb/tb_func_dispatch.sv
// Directed bench for func_dispatch with a variable-latency func stand-in and hand-computed results.
module tb_func_dispatch;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    func_dispatch_if ifc();

`ifdef FUNC_DISPATCH_CNT_EN
    logic [15:0] cnt;
`endif

    func_dispatch #(.DEPTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (ifc)
`ifdef FUNC_DISPATCH_CNT_EN
        ,
        .cnt_bo(cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // func stand-in: busy the cycle after start, 1..4 cycles of latency keyed on a.
    function automatic logic [24:0] fn_model(input logic [7:0] a, input logic [7:0] b);
        logic [24:0] r;
        logic [24:0] s;
        s = 0;
        for (int i = 0; i < 16; i++) if (i * i <= int'(b)) s = 25'(i);
        r = 25'(a) * 25'(a) * 25'(a) + s;
        return r;
    endfunction

    logic [7:0] fa, fb;
    logic [2:0] flat;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifc.fn_busy_i <= 1'b0;
            ifc.fn_y_bi   <= '0;
            flat          <= '0;
        end else if (ifc.fn_start_o) begin
            ifc.fn_busy_i <= 1'b1;
            fa            <= ifc.fn_a_bo;
            fb            <= ifc.fn_b_bo;
            flat          <= {1'b0, ifc.fn_a_bo[1:0]} + 3'd1;
        end else if (ifc.fn_busy_i) begin
            if (flat == 0) begin
                ifc.fn_busy_i <= 1'b0;
                ifc.fn_y_bi   <= fn_model(fa, fb);
            end else begin
                flat <= flat - 3'd1;
            end
        end
    end

    logic [24:0] got_q[$];
    int starts = 0, dbl_start = 0, ov_cycles = 0;
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifc.out_valid_o && ifc.out_ready_i) got_q.push_back(ifc.y_bo);
            if (ifc.out_valid_o) ov_cycles++;
            if (ifc.fn_start_o) begin
                starts++;
                if (prev_start) dbl_start++;
            end
            prev_start = ifc.fn_start_o;
        end
    end

    function automatic logic [31:0] got(input int i);
        return (got_q.size() > i) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
    endfunction

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int guard;
        @(negedge clk);
        ifc.in_valid_i = 1'b1;
        ifc.a_bi = a;
        ifc.b_bi = b;
        guard = 0;
        while (!ifc.in_ready_o && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check_eq("push_timeout", 32'(guard), 0);
        @(posedge clk);
        #1 ifc.in_valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int guard;
        guard = 0;
        while (got_q.size() < n && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (got_q.size() < n) check_eq("result_timeout", 32'(got_q.size()), 32'(n));
    endtask

    int s0;

    initial begin
        ifc.in_valid_i  = 1'b0;
        ifc.a_bi        = '0;
        ifc.b_bi        = '0;
        ifc.out_ready_i = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_in_ready", ifc.in_ready_o, 1);
        check_eq("rst_out_valid", ifc.out_valid_o, 0);
        check_eq("rst_y", ifc.y_bo, 0);
        check_eq("rst_fn_start", ifc.fn_start_o, 0);
        check_eq("rst_fn_a", ifc.fn_a_bo, 0);
        check_eq("rst_fn_b", ifc.fn_b_bo, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Single job
        push(8'd2, 8'd10);
        wait_results(1);
        repeat (3) @(negedge clk);
        check_eq("single_y", got(0), 11);
        check_eq("single_starts", 32'(starts), 1);
        check_eq("single_ov_cycles", 32'(ov_cycles), 1);

        // Back-to-back
        push(8'd255, 8'd255);
        push(8'd16, 8'd143);
        push(8'd43, 8'd11);
        wait_results(4);
        check_eq("b2b_0", got(1), 16581390);
        check_eq("b2b_1", got(2), 4107);
        check_eq("b2b_2", got(3), 79510);

        // Backpressure
        @(negedge clk);
        ifc.out_ready_i = 1'b0;
        push(8'd2, 8'd10);
        push(8'd255, 8'd255);
        push(8'd16, 8'd143);
        push(8'd43, 8'd11);
        push(8'd54, 8'd11);
        repeat (30) @(negedge clk);
        check_eq("bp_in_ready", ifc.in_ready_o, 0);
        check_eq("bp_out_valid", ifc.out_valid_o, 1);
        check_eq("bp_y_held", ifc.y_bo, 11);
        check_eq("bp_none_drained", 32'(got_q.size()), 4);
        ifc.out_ready_i = 1'b1;
        push(8'd3, 8'd4);
        wait_results(10);
        check_eq("bp_0", got(4), 11);
        check_eq("bp_1", got(5), 16581390);
        check_eq("bp_2", got(6), 4107);
        check_eq("bp_3", got(7), 79510);
        check_eq("bp_4", got(8), 157467);
        check_eq("bp_5", got(9), 29);
`ifdef FUNC_DISPATCH_CNT_EN
        repeat (2) @(negedge clk);
        check_eq("cnt_10", cnt, 10);
`endif

        // Edge values
        push(8'd0, 8'd0);
        push(8'd1, 8'd1);
        push(8'd200, 8'd200);
        wait_results(13);
        check_eq("edge_0", got(10), 0);
        check_eq("edge_1", got(11), 2);
        check_eq("edge_2", got(12), 8000014);

        // Reset while in WAIT with two entries queued
        repeat (5) @(negedge clk);
        push(8'd7, 8'd9);
        push(8'd5, 8'd9);
        push(8'd6, 8'd9);
        rst_n = 1'b0;
        #1;
        check_eq("rrst_out_valid", ifc.out_valid_o, 0);
        check_eq("rrst_in_ready", ifc.in_ready_o, 1);
        check_eq("rrst_fn_start", ifc.fn_start_o, 0);
        check_eq("rrst_fn_a", ifc.fn_a_bo, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        s0 = starts;
        repeat (30) @(negedge clk);
        check_eq("rrst_no_start", 32'(starts), 32'(s0));
        check_eq("rrst_no_result", 32'(got_q.size()), 13);
        check_eq("start_single_cycle", 32'(dbl_start), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
